// File: rtl/ldpc_3gpp_enc_p3_buf.sv
// Ping-pong output buffer for the P3 words of the LDPC encoder: the ACU stage fills one bank
// while the other bank is streamed out through a valid/ready output register.
//
// state | meaning
// IDLE  | waiting for the current read bank to become full
// READ  | issuing one RAM address per cycle while the output register can take a word
// DRAIN | all addresses issued, waiting for the eof word to be accepted
module ldpc_3gpp_enc_p3_buf #(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8,
  parameter int pBANKS  = 2
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic [pADDR_W-1:0] iused_nwords,
  input  logic               iwrite,
  input  logic               iwstart,
  input  logic [pDAT_W-1:0]  iwdat,
  input  logic               ordy,
  output logic               oval,
  output logic [1:0]         ostrb,
  output logic [pDAT_W-1:0]  odat,
  output logic               ofull,
  output logic               oerr
);

  localparam int cDEPTH = pBANKS * (2 ** pADDR_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [pADDR_W-1:0]             waddr_q, waddr_d;
  logic                           wbank_q, wbank_d;
  logic [pADDR_W-1:0]             wlen_q, wlen_d;
  logic                           started_q, started_d;
  logic [pBANKS-1:0][pADDR_W-1:0] blen_q, blen_d;
  logic [pBANKS-1:0]              full_q, full_d;
  logic                           ofull_q, ofull_d;
  logic                           oerr_q, oerr_d;

  logic [pADDR_W-1:0]             raddr_q, raddr_d;
  logic                           rbank_q, rbank_d;
  logic                           oval_q, oval_d;
  logic [1:0]                     ostrb_q, ostrb_d;
  logic [pDAT_W-1:0]              odat_q, odat_d;

  logic [pDAT_W-1:0]              ram [0:cDEPTH-1];
  logic                           ram_we;
  logic [pADDR_W:0]               ram_waddr;
  logic [pDAT_W-1:0]              ram_wdat;

  logic                           wr_cmpl;
  logic [pADDR_W-1:0]             cmpl_len;
  logic [pADDR_W-1:0]             rlen;
  logic                           rd_issue;
  logic                           rd_done;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q   <= ST_IDLE;
      waddr_q   <= '0;
      wbank_q   <= 1'b0;
      wlen_q    <= '0;
      started_q <= 1'b0;
      blen_q    <= '0;
      full_q    <= '0;
      ofull_q   <= 1'b0;
      oerr_q    <= 1'b0;
      raddr_q   <= '0;
      rbank_q   <= 1'b0;
      oval_q    <= 1'b0;
      ostrb_q   <= 2'b00;
      odat_q    <= '0;
    end else if (iclkena) begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      wbank_q   <= wbank_d;
      wlen_q    <= wlen_d;
      started_q <= started_d;
      blen_q    <= blen_d;
      full_q    <= full_d;
      ofull_q   <= ofull_d;
      oerr_q    <= oerr_d;
      raddr_q   <= raddr_d;
      rbank_q   <= rbank_d;
      oval_q    <= oval_d;
      ostrb_q   <= ostrb_d;
      odat_q    <= odat_d;
    end
  end

  // Block storage is plain RAM; reset only clears the bookkeeping around it.
  always_ff @(posedge iclk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdat;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_issue && (raddr_q == rlen)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rlen     = blen_q[rbank_q];
    rd_issue = (state_q == ST_READ) && (!oval_q || ordy);
    rd_done  = (state_q == ST_DRAIN) && oval_q && ordy;

    raddr_d = raddr_q;
    rbank_d = rbank_q;
    oval_d  = oval_q;
    ostrb_d = ostrb_q;
    odat_d  = odat_q;

    if (oval_q && ordy) begin
      oval_d = 1'b0;
    end
    // The RAM read is captured straight into the output register: one cycle of latency.
    if (rd_issue) begin
      oval_d  = 1'b1;
      odat_d  = ram[{rbank_q, raddr_q}];
      ostrb_d = {raddr_q == '0, raddr_q == rlen};
      raddr_d = raddr_q + pADDR_W'(1);
    end
    if (state_q == ST_IDLE) begin
      raddr_d = '0;
    end
    if (rd_done) begin
      rbank_d = ~rbank_q;
    end
  end

  always_comb begin
    waddr_d   = waddr_q;
    wbank_d   = wbank_q;
    wlen_d    = wlen_q;
    started_d = started_q;
    blen_d    = blen_q;
    oerr_d    = oerr_q;
    ram_we    = 1'b0;
    ram_waddr = {wbank_q, waddr_q};
    ram_wdat  = iwdat;
    wr_cmpl   = 1'b0;
    cmpl_len  = wlen_q;

    if (iclkena && iwrite) begin
      if (&full_q) begin
        oerr_d = 1'b1;
      end else if (iwstart) begin
        ram_we    = 1'b1;
        ram_waddr = {wbank_q, {pADDR_W{1'b0}}};
        wlen_d    = iused_nwords;
        started_d = 1'b1;
        waddr_d   = pADDR_W'(1);
        // A one-word block is complete on its start word.
        if (iused_nwords == '0) begin
          wr_cmpl  = 1'b1;
          cmpl_len = '0;
        end
      end else if (started_q) begin
        ram_we = 1'b1;
        if (waddr_q == wlen_q) begin
          wr_cmpl = 1'b1;
        end else begin
          waddr_d = waddr_q + pADDR_W'(1);
        end
      end
    end

    if (wr_cmpl) begin
      waddr_d         = '0;
      wbank_d         = ~wbank_q;
      started_d       = 1'b0;
      blen_d[wbank_q] = cmpl_len;
    end
  end

  // Setting after clearing lets a completing write win over a completing read on the same bank.
  always_comb begin
    full_d = full_q;
    if (rd_done) begin
      full_d[rbank_q] = 1'b0;
    end
    if (wr_cmpl) begin
      full_d[wbank_q] = 1'b1;
    end
    ofull_d = &full_d;
  end

  assign oval  = oval_q;
  assign ostrb = ostrb_q;
  assign odat  = odat_q;
  assign ofull = ofull_q;
  assign oerr  = oerr_q;

endmodule
